// File: rtl/hd_pkg.sv
// Shared defaults and the sequencer state type for the HD feature-accumulation blocks.
package hd_pkg;

    localparam int HD_INPUT_WIDTH = 8;
    localparam int HD_DIM_WIDTH   = 16;
    localparam int HD_FTSIZE      = 32;
    localparam int HD_CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StDone
    } seq_state_t;

endpackage

// File: rtl/pipelined_adder_tree_32.sv
// Registered reduction of one feature chunk plus a carried-in partial sum.
// The result wraps modulo 2^DIM_WIDTH; no saturation anywhere.
module pipelined_adder_tree_32
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = HD_INPUT_WIDTH,
    parameter int DIM_WIDTH   = HD_DIM_WIDTH,
    parameter int FTSIZE      = HD_FTSIZE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [FTSIZE-1:0][INPUT_WIDTH-1:0]  in_chunk,
    input  logic signed [DIM_WIDTH-1:0]         last_in,
    output logic signed [DIM_WIDTH-1:0]         sum_out
);

    logic signed [DIM_WIDTH-1:0] sum_d;
    logic signed [DIM_WIDTH-1:0] sum_q;

    // Sign-extend every element and fold it onto the carried-in sum.
    always_comb begin
        sum_d = last_in;
        for (int i = 0; i < FTSIZE; i++) begin
            sum_d = sum_d + DIM_WIDTH'($signed(in_chunk[i]));
        end
    end

    // Output register; cleared by the block reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;

endmodule

// File: rtl/adder_tree_sequencer.sv
// Sequences a run of feature chunks through one adder tree and hands the
// accumulated dimension sum out over a valid/ready port.
// Optional build macro: HD_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module adder_tree_sequencer
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = HD_INPUT_WIDTH,
    parameter int DIM_WIDTH   = HD_DIM_WIDTH,
    parameter int FTSIZE      = HD_FTSIZE,
    parameter int CNT_WIDTH   = HD_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [CNT_WIDTH-1:0]                cfg_num_chunks,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FTSIZE-1:0][INPUT_WIDTH-1:0]  in_chunk,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [DIM_WIDTH-1:0]         out_sum,
    output logic                                busy
`ifdef HD_SEQ_PERF_EN
    ,
    output logic [31:0]                         perf_busy_cycles,
    output logic [31:0]                         perf_stall_cycles
`endif
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    seq_state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 first_q, first_d;
    logic signed [DIM_WIDTH-1:0] sum_q, sum_d;

    logic                               accept;
    logic [FTSIZE-1:0][INPUT_WIDTH-1:0] tree_chunk;
    logic signed [DIM_WIDTH-1:0]        tree_last;
    logic signed [DIM_WIDTH-1:0]        tree_sum;

    assign accept  = in_ready && in_valid;
    assign cnt_inc = cnt_q + CntOne;

    // Tree feed: bubbles add zero, and the first chunk starts from zero so a
    // stale sum from the previous run never leaks in.
    always_comb begin
        tree_chunk = accept ? in_chunk : '0;
        tree_last  = (first_q && accept) ? '0 : tree_sum;
    end

    pipelined_adder_tree_32 #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .DIM_WIDTH   (DIM_WIDTH),
        .FTSIZE      (FTSIZE)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .in_chunk (tree_chunk),
        .last_in  (tree_last),
        .sum_out  (tree_sum)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        sum_d     = sum_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_num_chunks != '0) begin
                        num_d   = cfg_num_chunks;
                        cnt_d   = '0;
                        first_d = 1'b1;
                        state_d = StAccum;
                    end else begin
                        sum_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Tree register now holds the complete sum.
                sum_d   = tree_sum;
                cnt_d   = '0;
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            num_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            sum_q   <= sum_d;
        end
    end

    assign out_sum = sum_q;

`ifdef HD_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    // Saturating activity counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == StAccum) && !in_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Self-checking bench for adder_tree_sequencer: directed cases plus randomized runs,
// all compared every cycle against a transaction-level model.
module tb_adder_tree_sequencer;

    typedef logic [31:0][7:0] chunk_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_num_chunks;
    logic        in_valid;
    logic        in_ready;
    chunk_t      in_chunk;
    logic        out_valid;
    logic        out_ready;
    logic signed [15:0] out_sum;
    logic        busy;
`ifdef HD_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    adder_tree_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_num_chunks (cfg_num_chunks),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_chunk       (in_chunk),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum),
        .busy           (busy)
`ifdef HD_SEQ_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int chunk_sum(input chunk_t c);
        int s = 0;
        for (int i = 0; i < 32; i++) s += $signed(c[i]);
        return s;
    endfunction

    function automatic chunk_t fill(input logic [7:0] v);
        chunk_t c;
        for (int i = 0; i < 32; i++) c[i] = v;
        return c;
    endfunction

    function automatic chunk_t rand_chunk();
        chunk_t c;
        for (int i = 0; i < 32; i++) c[i] = 8'($urandom);
        return c;
    endfunction

    // ---------------- transaction-level reference model ----------------
    int          m_rem = 0;      // chunks still owed in the current run
    bit          m_drain = 0;    // last chunk taken, result appears next cycle
    bit          m_pend = 0;     // result offered, waiting for consumer
    int          m_acc = 0;      // plain integer running sum
    logic [15:0] m_sum = '0;
    int          m_busy_cnt = 0;
    int          m_stall_cnt = 0;
    bit          m_busy;

    assign m_busy = (m_rem != 0) || m_drain || m_pend;

    always @(posedge clk) begin
        if (reset) begin
            m_rem       <= 0;
            m_drain     <= 0;
            m_pend      <= 0;
            m_acc       <= 0;
            m_sum       <= '0;
            m_busy_cnt  <= 0;
            m_stall_cnt <= 0;
        end else begin
            if (m_busy) m_busy_cnt <= m_busy_cnt + 1;
            if (m_rem != 0 && !in_valid) m_stall_cnt <= m_stall_cnt + 1;
            if (!m_busy) begin
                if (start) begin
                    if (cfg_num_chunks != 0) begin
                        m_rem <= int'(cfg_num_chunks);
                        m_acc <= 0;
                    end else begin
                        m_sum  <= '0;
                        m_pend <= 1;
                    end
                end
            end else if (m_rem != 0) begin
                if (in_valid) begin
                    m_acc <= m_acc + chunk_sum(in_chunk);
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) m_drain <= 1;
                end
            end else if (m_drain) begin
                m_drain <= 0;
                m_pend  <= 1;
                m_sum   <= 16'(m_acc);
            end else if (out_ready) begin
                m_pend <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_rem != 0});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_pend});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("out_sum", {16'h0, out_sum}, {16'h0, m_sum});
`ifdef HD_SEQ_PERF_EN
            chk("perf_busy", perf_busy_cycles, 32'(m_busy_cnt));
            chk("perf_stall", perf_stall_cycles, 32'(m_stall_cnt));
`endif
        end
    end

    // ---------------- drivers ----------------
    bit rand_start = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic start_acc(input int n);
        start = 1'b1;
        cfg_num_chunks = 8'(n);
        step();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_chunk(input chunk_t c, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            in_chunk = rand_chunk();
            step();
        end
        in_valid = 1'b1;
        in_chunk = c;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        in_chunk = rand_chunk();
        if (rand_start) begin
            start = 1'($urandom_range(0, 1));
            cfg_num_chunks = 8'($urandom_range(0, 5));
        end
    endtask

    task automatic wait_result(input int hold, input bit start_on_hs,
                               output int lat, output logic [15:0] got);
        int n = 0;
        start = 1'b0;
        out_ready = 1'b0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) chk("out_valid_timeout", 32'd0, 32'd1);
        lat = cyc - start_cyc;
        got = out_sum;
        repeat (hold) step();
        out_ready = 1'b1;
        if (start_on_hs) begin
            start = 1'b1;
            cfg_num_chunks = 8'd3;
        end
        step();
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [15:0] got;
        chunk_t mixed;

        reset = 1'b1;
        start = 1'b0;
        cfg_num_chunks = '0;
        in_valid = 1'b0;
        in_chunk = '0;
        out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'h0, out_sum}, 32'd0);
        step();

        // Four back-to-back chunks of +1.
        start_acc(4);
        repeat (4) send_chunk(fill(8'h01), 0);
        wait_result(0, 0, lat, got);
        chk("ones_latency", 32'(lat), 32'd5);
        chk("ones_sum", {16'h0, got}, 32'd128);
        chk("ones_model", {16'h0, m_sum}, 32'd128);

        // Cancelling chunk, three-cycle stall, then +1 chunk.
        do_reset();
        for (int i = 0; i < 32; i++) mixed[i] = (i < 16) ? 8'hFF : 8'h01;
        start_acc(2);
        send_chunk(mixed, 0);
        send_chunk(fill(8'h01), 3);
        wait_result(0, 0, lat, got);
        chk("stall_sum", {16'h0, got}, 32'd32);
`ifdef HD_SEQ_PERF_EN
        chk("stall_count", perf_stall_cycles, 32'd3);
`endif

        // Wrap-around with -128 everywhere.
        start_acc(9);
        repeat (9) send_chunk(fill(8'h80), 0);
        wait_result(0, 0, lat, got);
        chk("wrap9_sum", {16'h0, got}, 32'h7000);
        start_acc(8);
        repeat (8) send_chunk(fill(8'h80), 0);
        wait_result(1, 0, lat, got);
        chk("wrap8_sum", {16'h0, got}, 32'h8000);
        chk("wrap8_model", {16'h0, m_sum}, 32'h8000);

        // Zero-chunk run with a slow consumer and a start during the handshake.
        start_acc(0);
        wait_result(4, 1, lat, got);
        chk("zero_latency", 32'(lat), 32'd0);
        chk("zero_sum", {16'h0, got}, 32'd0);
        chk("zero_idle_after", {31'b0, busy}, 32'd0);

        // Reset mid-run discards the partial sum.
        start_acc(4);
        send_chunk(fill(8'h05), 0);
        send_chunk(fill(8'h07), 0);
        do_reset();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {16'h0, out_sum}, 32'd0);
        start_acc(1);
        send_chunk(fill(8'h02), 0);
        wait_result(0, 0, lat, got);
        chk("after_rst_sum", {16'h0, got}, 32'd64);

        // Randomized runs: gaps, back-pressure, stray starts, garbage on idle data.
        rand_start = 1;
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(0, 5);
            start_acc(n);
            for (int k = 0; k < n; k++) send_chunk(rand_chunk(), $urandom_range(0, 2));
            wait_result($urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, got);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
